ht_cmd_arbiter: RTL and testbench
=================================

# ht_cmd_arbiter

Round-robin arbiter that shares the single hash table command port among `CLIENT_CNT` requesters and routes each result back to the client that issued it. It sits between the client logic and `hash_table_top`: it drives the table's command interface and consumes its result interface. Since the table returns results in command order, a tag FIFO of client indices is enough for routing.

## Interface
Parameters:
- `CLIENT_CNT`, 4: number of requesters, 2..16.
- `TAG_FIFO_DEPTH`, 16: maximum outstanding commands, power of two.
- `CID_W`, `$clog2(CLIENT_CNT)`: client index width (derived; do not override).

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `cl_cmd_i` in `CLIENT_CNT` x `ht_command_t`: per-client command.
- `cl_cmd_valid_i` in `CLIENT_CNT`: per-client command valid.
- `cl_cmd_ready_o` out `CLIENT_CNT`: per-client command accepted.
- `cl_res_o` out `ht_result_t`: result, shared bus.
- `cl_res_valid_o` out `CLIENT_CNT`: one-hot result valid, addressed to the issuing client.
- `cl_res_ready_i` in `CLIENT_CNT`: per-client result ready.
- `ht_cmd_o` out `ht_command_t`: command to the table.
- `ht_cmd_valid_o` out 1: command valid.
- `ht_cmd_ready_i` in 1: table accepts the command.
- `ht_res_i` in `ht_result_t`: result from the table.
- `ht_res_valid_i` in 1: result valid.
- `ht_res_ready_o` out 1: arbiter accepts the result.
- `outstanding_o` out `$clog2(TAG_FIFO_DEPTH)+1`: number of commands issued whose results have not yet returned.
- `tag_err_o` out 1: sticky flag. Set when a result arrives while no command is outstanding.

## Operation
- Request vector: `req = cl_cmd_valid_i`.
- Grant:
  - Combinational round-robin priority starting at `rr_ptr`.
  - The winner is the first set bit of `req` at or after `rr_ptr`, wrapping modulo `CLIENT_CNT`.
  - The grant is suppressed when the tag FIFO is full.
- Command path:
  - `ht_cmd_valid_o = |req && !fifo_full`; `ht_cmd_o = cl_cmd_i[winner]`.
  - `cl_cmd_ready_o[winner] = ht_cmd_ready_i && !fifo_full`; all other ready bits are 0.
- Issue event (`ht_cmd_valid_o && ht_cmd_ready_i`):
  - Push `winner` into the tag FIFO.
  - `rr_ptr <= (winner+1) mod CLIENT_CNT`.
- When there is no issue event, `rr_ptr` holds.
- Result path:
  - `head` is the tag at the FIFO head.
  - `cl_res_valid_o[head] = ht_res_valid_i && !fifo_empty`; `cl_res_o = ht_res_i`.
  - `ht_res_ready_o = fifo_empty || cl_res_ready_i[head]`.
  - Pop the FIFO on `ht_res_valid_i && ht_res_ready_o && !fifo_empty`.
  - A result arriving with the FIFO empty is consumed and dropped, and sets `tag_err_o`.
- `outstanding_o` always equals the FIFO occupancy.
- Push and pop in the same cycle: occupancy is unchanged, and both happen.
- FIFO full blocks a push even if a pop occurs in the same cycle. This avoids a ready→valid combinational loop.
- `tag_err_o` clears only on reset.

## Timing
- Command pass-through latency is 0 cycles (combinational); result routing is also 0 cycles.
- `rr_ptr`, the FIFO pointers/occupancy and `tag_err_o` update on the rising edge of `clk_i`.
- Reset values when `rst_n_i` is low at a clock edge:
  - `rr_ptr = 0`, FIFO empty, `outstanding_o = 0`, `tag_err_o = 0`.
  - Consequently `ht_cmd_valid_o` follows `req` (non-zero if any request is asserted) and all `cl_res_valid_o` are 0.
- Reset mid-operation: outstanding tags are discarded. The table is reset by the same reset, so no stale results are expected.
- Handshake rules: valid must not depend on ready. A client must hold its command stable while its valid is high and ready is low.
- Fairness: a continuously requesting client is granted within `CLIENT_CNT` issue events.

## Configuration
- Macro: `HT_CMD_ARBITER_STATS_EN`.
- Defined:
  - Adds output `stat_issue_cnt_o` (`CLIENT_CNT` x 32): per-client count of issue events.
  - Adds output `stat_block_cnt_o` (32): count of cycles with `|req` asserted but no issue.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `hash_table` holds `ht_command_t` and `ht_result_t`, plus a new `ht_client_id_t` typedef.
- Sub-module `ht_tag_fifo`: synchronous FIFO of width `CID_W`, depth `TAG_FIFO_DEPTH`, with full/empty/usedw outputs and first-word-fall-through read.
- The round-robin grant stays in `ht_cmd_arbiter`.

## Test plan
- Clients 0..3 all valid, `ht_cmd_ready_i=1` for 8 cycles → issue order 0,1,2,3,0,1,2,3; `outstanding_o=8`.
- `TAG_FIFO_DEPTH=4`, table never returns a result, client 1 always valid → 4 issues, then `ht_cmd_valid_o=0` and `cl_cmd_ready_o=0`.
- Issue INSERT from client 2, then SEARCH from client 0; table returns results R0, R1 → R0 shows `cl_res_valid_o=4'b0100`, R1 shows `4'b0001`; `outstanding_o` 2→0.
- Result pending for client 3 with `cl_res_ready_i[3]=0` for 5 cycles → `ht_res_ready_o=0` throughout; on ready=1, one pop.
- `ht_res_valid_i=1` with FIFO empty → `ht_res_ready_o=1`, no `cl_res_valid_o` asserted, `tag_err_o=1` next cycle and held.
- Reset asserted with 3 outstanding → next cycle `outstanding_o=0`, `rr_ptr=0`, `tag_err_o=0`; with the macro defined, the stat counters read 0.

Source files
------------

// File: rtl/hash_table.sv
// Shared hash table types: command/result payloads seen by the table's
// command and result ports, plus the client index type used by arbiters
// that share those ports.
package hash_table;

  localparam int HT_KEY_W       = 32;
  localparam int HT_VALUE_W     = 32;
  localparam int HT_MAX_CLIENTS = 16;

  typedef enum logic [1:0] {
    HT_OP_SEARCH = 2'd0,
    HT_OP_INSERT = 2'd1,
    HT_OP_DELETE = 2'd2,
    HT_OP_NOP    = 2'd3
  } ht_opcode_t;

  typedef enum logic [1:0] {
    HT_RSP_OK        = 2'd0,
    HT_RSP_NOT_FOUND = 2'd1,
    HT_RSP_FULL      = 2'd2,
    HT_RSP_ERR       = 2'd3
  } ht_status_t;

  typedef struct packed {
    ht_opcode_t            op;
    logic [HT_KEY_W-1:0]   key;
    logic [HT_VALUE_W-1:0] value;
  } ht_command_t;

  typedef struct packed {
    ht_opcode_t            op;
    ht_status_t            status;
    logic [HT_KEY_W-1:0]   key;
    logic [HT_VALUE_W-1:0] value;
  } ht_result_t;

  // Wide enough for the largest supported client count.
  typedef logic [$clog2(HT_MAX_CLIENTS)-1:0] ht_client_id_t;

endpackage

// File: rtl/ht_tag_fifo.sv
// Tag FIFO: remembers which client issued each outstanding command.
// First-word-fall-through: data_o shows the head entry whenever not empty.
// DEPTH must be a power of two (pointers wrap naturally).
module ht_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   usedw_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];
  assign usedw_o = count;

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/ht_cmd_arbiter.sv
// Round-robin arbiter sharing the hash table command port among CLIENT_CNT
// clients. Results come back in command order, so a FIFO of client tags
// routes each result to its issuer.
// Optional statistics counters: define HT_CMD_ARBITER_STATS_EN.
//
// Handshake: a transfer occurs on a cycle where valid and ready are both
// high; valid never depends on ready, and a sender holds its payload stable
// while valid is high and ready is low.
module ht_cmd_arbiter
  import hash_table::*;
#(
  parameter int CLIENT_CNT     = 4,
  parameter int TAG_FIFO_DEPTH = 16,
  parameter int CID_W          = $clog2(CLIENT_CNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  ht_command_t [CLIENT_CNT-1:0]       cl_cmd_i,
  input  logic [CLIENT_CNT-1:0]              cl_cmd_valid_i,
  output logic [CLIENT_CNT-1:0]              cl_cmd_ready_o,
  output ht_result_t                         cl_res_o,
  output logic [CLIENT_CNT-1:0]              cl_res_valid_o,
  input  logic [CLIENT_CNT-1:0]              cl_res_ready_i,
  output ht_command_t                        ht_cmd_o,
  output logic                               ht_cmd_valid_o,
  input  logic                               ht_cmd_ready_i,
  input  ht_result_t                         ht_res_i,
  input  logic                               ht_res_valid_i,
  output logic                               ht_res_ready_o,
  output logic [$clog2(TAG_FIFO_DEPTH):0]    outstanding_o,
  output logic                               tag_err_o
`ifdef HT_CMD_ARBITER_STATS_EN
  ,
  output logic [CLIENT_CNT-1:0][31:0]        stat_issue_cnt_o,
  output logic [31:0]                        stat_block_cnt_o
`endif
);

  logic [CLIENT_CNT-1:0] req;
  logic [CID_W-1:0]      rr_ptr;
  logic [CID_W-1:0]      winner;
  logic [CID_W-1:0]      cand;
  logic [CID_W:0]        sum;
  logic                  any_req;
  logic                  issue;
  logic                  pop;
  logic [CID_W-1:0]      head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  tag_err_q;

  assign req = cl_cmd_valid_i;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < CLIENT_CNT; i++) begin
      sum = {1'b0, rr_ptr} + (CID_W+1)'(i);
      if (sum >= (CID_W+1)'(CLIENT_CNT)) sum = sum - (CID_W+1)'(CLIENT_CNT);
      cand = sum[CID_W-1:0];
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Command path: the grant is withheld while no tag slot is free, so the
  // valid depends only on requests and registered FIFO state.
  always_comb begin
    ht_cmd_valid_o = any_req && !fifo_full;
    ht_cmd_o       = cl_cmd_i[winner];
    cl_cmd_ready_o = '0;
    if (any_req && !fifo_full && ht_cmd_ready_i) cl_cmd_ready_o[winner] = 1'b1;
  end

  assign issue = ht_cmd_valid_o && ht_cmd_ready_i;

  // Result path: route to the client at the tag FIFO head; with no tag the
  // result is swallowed so the table never stalls on a stray result.
  always_comb begin
    cl_res_o       = ht_res_i;
    cl_res_valid_o = '0;
    if (ht_res_valid_i && !fifo_empty) cl_res_valid_o[head] = 1'b1;
    ht_res_ready_o = fifo_empty || cl_res_ready_i[head];
  end

  assign pop = ht_res_valid_i && ht_res_ready_o && !fifo_empty;

  // Rotate priority to just past the last winner on every issue.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (winner == CID_W'(CLIENT_CNT - 1)) ? '0 : winner + CID_W'(1);
    end
  end

  // Sticky flag for results that arrive with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tag_err_q <= 1'b0;
    end else if (ht_res_valid_i && fifo_empty) begin
      tag_err_q <= 1'b1;
    end
  end

  assign tag_err_o = tag_err_q;

  ht_tag_fifo #(
    .WIDTH (CID_W),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (issue),
    .data_i  (winner),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usedw_o (outstanding_o)
  );

`ifdef HT_CMD_ARBITER_STATS_EN
  logic [CLIENT_CNT-1:0][31:0] issue_cnt_q;
  logic [31:0]                 block_cnt_q;

  // Per-client issue counts and blocked-request cycle count, wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      issue_cnt_q <= '0;
      block_cnt_q <= '0;
    end else begin
      for (int c = 0; c < CLIENT_CNT; c++) begin
        if (issue && (winner == CID_W'(c))) issue_cnt_q[c] <= issue_cnt_q[c] + 32'd1;
      end
      if (any_req && !issue) block_cnt_q <= block_cnt_q + 32'd1;
    end
  end

  assign stat_issue_cnt_o = issue_cnt_q;
  assign stat_block_cnt_o = block_cnt_q;
`endif

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Bench for ht_cmd_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_ht_cmd_arbiter;
  import hash_table::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int CID_W = $clog2(N);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ht_command_t [N-1:0] cl_cmd;
  logic [N-1:0]        cl_cmd_valid;
  logic [N-1:0]        cl_cmd_ready;
  ht_result_t          cl_res;
  logic [N-1:0]        cl_res_valid;
  logic [N-1:0]        cl_res_ready;
  ht_command_t         ht_cmd;
  logic                ht_cmd_valid;
  logic                ht_cmd_ready;
  ht_result_t          ht_res;
  logic                ht_res_valid;
  logic                ht_res_ready;
  logic [CNT_W-1:0]    outstanding;
  logic                tag_err;
`ifdef HT_CMD_ARBITER_STATS_EN
  logic [N-1:0][31:0]  stat_issue_cnt;
  logic [31:0]         stat_block_cnt;
`endif

  ht_cmd_arbiter #(
    .CLIENT_CNT     (N),
    .TAG_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cl_cmd_i       (cl_cmd),
    .cl_cmd_valid_i (cl_cmd_valid),
    .cl_cmd_ready_o (cl_cmd_ready),
    .cl_res_o       (cl_res),
    .cl_res_valid_o (cl_res_valid),
    .cl_res_ready_i (cl_res_ready),
    .ht_cmd_o       (ht_cmd),
    .ht_cmd_valid_o (ht_cmd_valid),
    .ht_cmd_ready_i (ht_cmd_ready),
    .ht_res_i       (ht_res),
    .ht_res_valid_i (ht_res_valid),
    .ht_res_ready_o (ht_res_ready),
    .outstanding_o  (outstanding),
    .tag_err_o      (tag_err)
`ifdef HT_CMD_ARBITER_STATS_EN
    ,
    .stat_issue_cnt_o (stat_issue_cnt),
    .stat_block_cnt_o (stat_block_cnt)
`endif
  );

  // ---------------- scoreboard / model ----------------
  logic [CID_W-1:0] exp_q[$];      // client tags of commands in flight
  int               rr;            // next client with top priority
  bit               err_m;
  bit               model_on;
  int unsigned      issue_m[N];
  int unsigned      block_m;
  bit               ev_issue, ev_pop, ev_err, ev_any;
  int               ev_win;
  int               total;
  int               bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Derive this cycle's expected outputs from the rules, compare, and
  // remember what will happen at the coming clock edge.
  task automatic check_model();
    int win;
    bit any, full, empty;
    logic [N-1:0] e_ready, e_res_valid;
    logic e_res_ready, e_cmd_valid;
    full  = (exp_q.size() == DEPTH);
    empty = (exp_q.size() == 0);
    any = 0;
    win = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr + k) % N;
      if (!any && cl_cmd_valid[c]) begin
        any = 1;
        win = c;
      end
    end
    e_cmd_valid = any && !full;
    e_ready = '0;
    if (e_cmd_valid && ht_cmd_ready) e_ready[win] = 1'b1;
    e_res_valid = '0;
    if (ht_res_valid && !empty) e_res_valid[exp_q[0]] = 1'b1;
    e_res_ready = empty ? 1'b1 : cl_res_ready[exp_q[0]];
    if (model_on) begin
      chk("cmd_valid", ht_cmd_valid, e_cmd_valid);
      chk("cmd_ready", cl_cmd_ready, e_ready);
      if (e_cmd_valid) chk("cmd_data", ht_cmd, cl_cmd[win]);
      chk("res_valid", cl_res_valid, e_res_valid);
      chk("res_ready", ht_res_ready, e_res_ready);
      chk("res_data", cl_res, ht_res);
      chk("outstanding", outstanding, exp_q.size());
      chk("tag_err", tag_err, err_m);
`ifdef HT_CMD_ARBITER_STATS_EN
      for (int c = 0; c < N; c++) chk($sformatf("stat_issue%0d", c), stat_issue_cnt[c], issue_m[c]);
      chk("stat_block", stat_block_cnt, block_m);
`endif
    end
    ev_any   = any;
    ev_win   = win;
    ev_issue = e_cmd_valid && ht_cmd_ready;
    ev_pop   = ht_res_valid && e_res_ready && !empty;
    ev_err   = ht_res_valid && empty;
  endtask

  task automatic update_model();
    if (!rst_n) begin
      exp_q.delete();
      rr = 0;
      err_m = 0;
      for (int c = 0; c < N; c++) issue_m[c] = 0;
      block_m = 0;
      model_on = 1;
    end else if (model_on) begin
      if (ev_pop) void'(exp_q.pop_front());
      if (ev_issue) begin
        exp_q.push_back(CID_W'(ev_win));
        rr = (ev_win + 1) % N;
        issue_m[ev_win]++;
      end
      if (ev_any && !ev_issue) block_m++;
      if (ev_err) err_m = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic finish_cycle();
    #1;
    check_model();
    @(posedge clk);
    update_model();
  endtask

  task automatic idle_inputs();
    cl_cmd_valid = '0;
    ht_cmd_ready = 1'b0;
    ht_res_valid = 1'b0;
    cl_res_ready = '1;
  endtask

  task automatic rand_cmd(input int c);
    cl_cmd[c].op    = ht_opcode_t'($urandom_range(0, 3));
    cl_cmd[c].key   = $urandom;
    cl_cmd[c].value = $urandom;
  endtask

  task automatic rand_res();
    ht_res.op     = ht_opcode_t'($urandom_range(0, 3));
    ht_res.status = ht_status_t'($urandom_range(0, 3));
    ht_res.key    = $urandom;
    ht_res.value  = $urandom;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      rst_n = 1'b0;
      idle_inputs();
      finish_cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  int order_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [N-1:0] last_acc;

  initial begin
    total = 0;
    bad = 0;
    model_on = 0;
    rr = 0;
    rst_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < N; c++) rand_cmd(c);
    rand_res();

    // Reset state and round-robin order with all clients requesting.
    do_reset();
    begin_cycle();
    idle_inputs();
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_tag_err", tag_err, 0);
    chk("rst_res_valid", cl_res_valid, 0);
    chk("rst_cmd_valid_idle", ht_cmd_valid, 0);
    finish_cycle();
    for (int i = 0; i < 8; i++) begin
      begin_cycle();
      cl_cmd_valid = '1;
      ht_cmd_ready = 1'b1;
      #1;
      chk("rr_order", cl_cmd_ready, N'(1) << order_a[i]);
      finish_cycle();
    end
    begin_cycle();
    cl_cmd_valid = '1;
    ht_cmd_ready = 1'b1;
    #1;
    chk("full_outstanding", outstanding, 8);
    chk("full_cmd_valid", ht_cmd_valid, 0);
    chk("full_cmd_ready", cl_cmd_ready, 0);
    finish_cycle();

    // Single requester, table never answers: blocks once the tags run out.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      begin_cycle();
      cl_cmd_valid = 4'b0010;
      ht_cmd_ready = 1'b1;
      #1;
      chk("blk_cmd_valid", ht_cmd_valid, (i < DEPTH) ? 1'b1 : 1'b0);
      chk("blk_cmd_ready", cl_cmd_ready, (i < DEPTH) ? 4'b0010 : 4'b0000);
      finish_cycle();
    end

    // INSERT from client 2, SEARCH from client 0, results routed in order.
    do_reset();
    begin_cycle();
    cl_cmd[2].op = HT_OP_INSERT;
    cl_cmd_valid = 4'b0100;
    ht_cmd_ready = 1'b1;
    #1;
    chk("c_ins_ready", cl_cmd_ready, 4'b0100);
    chk("c_ins_op", ht_cmd.op, HT_OP_INSERT);
    finish_cycle();
    begin_cycle();
    cl_cmd[0].op = HT_OP_SEARCH;
    cl_cmd_valid = 4'b0001;
    ht_cmd_ready = 1'b1;
    #1;
    chk("c_srch_ready", cl_cmd_ready, 4'b0001);
    chk("c_srch_op", ht_cmd.op, HT_OP_SEARCH);
    finish_cycle();
    begin_cycle();
    idle_inputs();
    rand_res();
    ht_res_valid = 1'b1;
    #1;
    chk("c_out2", outstanding, 2);
    chk("c_r0_valid", cl_res_valid, 4'b0100);
    finish_cycle();
    begin_cycle();
    idle_inputs();
    rand_res();
    ht_res_valid = 1'b1;
    #1;
    chk("c_out1", outstanding, 1);
    chk("c_r1_valid", cl_res_valid, 4'b0001);
    finish_cycle();
    begin_cycle();
    idle_inputs();
    #1;
    chk("c_out0", outstanding, 0);
    finish_cycle();

    // Client 3 holds off its result for 5 cycles.
    do_reset();
    begin_cycle();
    cl_cmd_valid = 4'b1000;
    ht_cmd_ready = 1'b1;
    finish_cycle();
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      idle_inputs();
      ht_res_valid = 1'b1;
      cl_res_ready = 4'b0111;
      #1;
      chk("d_res_ready", ht_res_ready, 0);
      chk("d_res_valid", cl_res_valid, 4'b1000);
      chk("d_out", outstanding, 1);
      finish_cycle();
    end
    begin_cycle();
    idle_inputs();
    ht_res_valid = 1'b1;
    #1;
    chk("d_res_ready_go", ht_res_ready, 1);
    finish_cycle();
    begin_cycle();
    idle_inputs();
    #1;
    chk("d_out_after", outstanding, 0);
    finish_cycle();

    // Stray result with nothing outstanding.
    do_reset();
    begin_cycle();
    idle_inputs();
    ht_res_valid = 1'b1;
    #1;
    chk("e_res_ready", ht_res_ready, 1);
    chk("e_res_valid", cl_res_valid, 0);
    chk("e_tag_err_pre", tag_err, 0);
    finish_cycle();
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      idle_inputs();
      #1;
      chk("e_tag_err_held", tag_err, 1);
      finish_cycle();
    end

    // Reset with 3 outstanding clears everything, priority back to client 0.
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      cl_cmd_valid = '1;
      ht_cmd_ready = 1'b1;
      finish_cycle();
    end
    begin_cycle();
    rst_n = 1'b0;
    cl_cmd_valid = '1;
    ht_cmd_ready = 1'b0;
    #1;
    chk("f_out3", outstanding, 3);
    chk("f_valid_in_rst", ht_cmd_valid, 1);
    finish_cycle();
    begin_cycle();
    cl_cmd_valid = '1;
    ht_cmd_ready = 1'b1;
    #1;
    chk("f_out0", outstanding, 0);
    chk("f_tag_err0", tag_err, 0);
    chk("f_rr0", cl_cmd_ready, 4'b0001);
`ifdef HT_CMD_ARBITER_STATS_EN
    chk("f_stat_block0", stat_block_cnt, 0);
    chk("f_stat_issue0", stat_issue_cnt, 0);
`endif
    finish_cycle();

    // Randomized traffic; clients keep a command until it is accepted.
    last_acc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      begin_cycle();
      rst_n = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < N; c++) begin
        if (!(cl_cmd_valid[c] && !last_acc[c])) begin
          cl_cmd_valid[c] = ($urandom_range(0, 1) == 1);
          rand_cmd(c);
        end
      end
      ht_cmd_ready = ($urandom_range(0, 3) != 0);
      ht_res_valid = ($urandom_range(0, 2) == 0);
      rand_res();
      for (int c = 0; c < N; c++) cl_res_ready[c] = ($urandom_range(0, 3) != 0);
      #1;
      last_acc = cl_cmd_valid & cl_cmd_ready;
      finish_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
